// File: rtl/SB_codex_pkg.sv
// Sideband codec types shared by the sideband receive path and LTSM consumers.
// Header layout, opcode/message enums and the header reset value.
package SB_codex_pkg;

    typedef enum logic [4:0] {
        Register_Access_Req   = 5'b00001,
        Message_without_Data  = 5'b10010,
        Message_with_64b_Data = 5'b11011
    } SB_opcode_t;

    typedef enum logic [7:0] {
        MSG_NONE                   = 8'h00,
        SBINIT_done_req            = 8'h01,
        SBINIT_done_resp           = 8'h02,
        MBINIT_PARAM_config_req    = 8'h10,
        MBINIT_PARAM_config_resp   = 8'h11,
        MBINIT_CAL_done_req        = 8'h12,
        MBINIT_CAL_done_resp       = 8'h13,
        MBINIT_REPAIRCLK_init_req  = 8'h14,
        MBINIT_REPAIRCLK_init_resp = 8'h15
    } SB_msg_num_t;

    typedef struct packed {
        SB_opcode_t  opcode;
        SB_msg_num_t msg_num;
        logic [15:0] msg_info;
    } SB_msg_t;

    function automatic SB_msg_t reset_SB_msg();
        SB_msg_t m;
        m.opcode   = Message_without_Data;
        m.msg_num  = MSG_NONE;
        m.msg_info = '0;
        return m;
    endfunction

endpackage

// File: rtl/sb_rx_msg_queue_fifo.sv
// Generic circular-buffer FIFO holding header+payload words.
// A push into a full buffer is only taken when a pop frees a slot that cycle.
module sb_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8,
    parameter int CW    = $clog2(DEPTH+1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_i,
    input  logic          push_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          pop_i,
    output logic [W-1:0]  rdata_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok, pop_ok;

    assign full_o  = (count_q == FULL_C);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rptr_q];

    assign pop_ok  = pop_i && !empty_o && !clr_i;
    assign push_ok = push_i && (!full_o || pop_ok) && !clr_i;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (clr_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push_ok) wptr_d = wptr_q + AW'(1);
            if (pop_ok)  rptr_d = rptr_q + AW'(1);
            if (push_ok && !pop_ok) count_d = count_q + CW'(1);
            if (pop_ok && !push_ok) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/sb_rx_msg_queue.sv
// Sideband RX message queue: buffers deserialized messages and serves them
// to an LTSM consumer over the available/req/valid pull handshake.
module sb_rx_msg_queue
    import SB_codex_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DROP_W = 8
) (
    input  logic                     clk_100MHz,
    input  logic                     reset,
    input  logic                     flush_i,
    input  SB_msg_t                  RX_msg_i,
    input  logic [63:0]              RX_dataBus_i,
    input  logic                     RX_msg_valid_i,
    output logic                     SB_RX_msg_available_o,
    input  logic                     SB_RX_msg_req_i,
    output logic                     SB_RX_msg_valid_o,
    output SB_msg_t                  SB_RX_msg_o,
    output logic [63:0]              SB_RX_dataBus_o,
    output logic                     overflow_o,
    output logic [DROP_W-1:0]        drop_cnt_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o
);

    localparam int LW = $clog2(DEPTH+1);
    localparam int W  = $bits(SB_msg_t) + 64;

    typedef enum logic [1:0] {IDLE, DELIVER, GAP} state_t;

    state_t            state_q, state_d;
    SB_msg_t           msg_q, msg_d;
    logic [63:0]       data_q, data_d;
    logic              ovf_q, ovf_d;
    logic [DROP_W-1:0] drop_q, drop_d;

    logic          full, empty, pop, push, drop;
    logic [W-1:0]  wdata, rdata;
    logic [LW-1:0] count;
    logic [63:0]   wpayload;

    assign wpayload = (RX_msg_i.opcode == Message_without_Data) ?
                      64'd0 : RX_dataBus_i;
    assign wdata    = {RX_msg_i, wpayload};
    assign push     = RX_msg_valid_i && !flush_i;
    assign drop     = push && full && !pop;

    sb_rx_fifo #(
        .DEPTH (DEPTH),
        .W     (W),
        .CW    (LW)
    ) u_fifo (
        .clk_i   (clk_100MHz),
        .rst_i   (reset),
        .clr_i   (flush_i),
        .push_i  (push),
        .wdata_i (wdata),
        .pop_i   (pop),
        .rdata_o (rdata),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    // GAP swallows the consumer's registered request left over from DELIVER
    always_comb begin
        state_d               = state_q;
        pop                   = 1'b0;
        SB_RX_msg_available_o = 1'b0;
        SB_RX_msg_valid_o     = 1'b0;
        unique case (state_q)
            IDLE: begin
                SB_RX_msg_available_o = !empty;
                if (SB_RX_msg_req_i && !empty) begin
                    pop     = 1'b1;
                    state_d = DELIVER;
                end
            end
            DELIVER: begin
                SB_RX_msg_valid_o = 1'b1;
                state_d           = GAP;
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush_i) begin
            pop     = 1'b0;
            state_d = IDLE;
        end
    end

    always_comb begin
        msg_d  = msg_q;
        data_d = data_q;
        ovf_d  = ovf_q;
        drop_d = drop_q;
        if (pop) begin
            msg_d  = SB_msg_t'(rdata[W-1:64]);
            data_d = rdata[63:0];
        end
        if (flush_i) begin
            ovf_d  = 1'b0;
            drop_d = '0;
        end else if (drop) begin
            ovf_d = 1'b1;
            if (drop_q != '1) drop_d = drop_q + DROP_W'(1);
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state_q <= IDLE;
            msg_q   <= reset_SB_msg();
            data_q  <= '0;
            ovf_q   <= 1'b0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            msg_q   <= msg_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
            drop_q  <= drop_d;
        end
    end

    assign SB_RX_msg_o     = msg_q;
    assign SB_RX_dataBus_o = data_q;
    assign overflow_o      = ovf_q;
    assign drop_cnt_o      = drop_q;
    assign level_o         = count;

endmodule

// File: tb/tb_sb_rx_msg_queue.sv
// Randomized and directed bench for sb_rx_msg_queue against a queue-based
// reference model of the pull handshake.
module tb_sb_rx_msg_queue;
    import SB_codex_pkg::*;

    localparam int DEPTH = 4;
    localparam int DW    = 8;

    logic        clk = 1'b0;
    logic        rst, fl, pv, rq;
    SB_msg_t     mi;
    logic [63:0] di;
    logic        avail, vld, ovf_o;
    SB_msg_t     mo;
    logic [63:0] dout;
    logic [DW-1:0] drop_o;
    logic [2:0]  level;

    always #5 clk = ~clk;

    sb_rx_msg_queue #(.DEPTH(DEPTH), .DROP_W(DW)) dut (
        .clk_100MHz            (clk),
        .reset                 (rst),
        .flush_i               (fl),
        .RX_msg_i              (mi),
        .RX_dataBus_i          (di),
        .RX_msg_valid_i        (pv),
        .SB_RX_msg_available_o (avail),
        .SB_RX_msg_req_i       (rq),
        .SB_RX_msg_valid_o     (vld),
        .SB_RX_msg_o           (mo),
        .SB_RX_dataBus_o       (dout),
        .overflow_o            (ovf_o),
        .drop_cnt_o            (drop_o),
        .level_o               (level)
    );

    typedef struct {
        SB_msg_t     m;
        logic [63:0] d;
    } ent_t;

    int n_chk = 0;
    int n_err = 0;

    // reference model: message queue plus cycles elapsed since last pop
    ent_t q[$];
    ent_t out;
    int   ph = 0;
    bit   m_ovf = 0;
    int   m_drops = 0;

    int          cyc = 0;
    int          pulses[$];
    logic [15:0] del_q[$];
    SB_msg_t     dmsg;
    logic [63:0] ddata;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_step();
        ent_t e;
        bit   popped;
        if (rst || fl) begin
            q.delete();
            ph      = 0;
            m_ovf   = 0;
            m_drops = 0;
            return;
        end
        popped = (ph == 0) && rq && (q.size() > 0);
        if (popped) out = q.pop_front();
        if (pv) begin
            e.m = mi;
            e.d = (mi.opcode == Message_without_Data) ? 64'd0 : di;
            if (q.size() < DEPTH) q.push_back(e);
            else begin
                m_ovf = 1;
                if (m_drops < 255) m_drops++;
            end
        end
        if (popped) ph = 1;
        else if (ph == 1) ph = 2;
        else ph = 0;
    endtask

    task automatic compare();
        chk("valid", 64'(vld), 64'(ph == 1));
        chk("avail", 64'(avail), 64'((ph == 0) && (q.size() > 0)));
        chk("level", 64'(level), 64'(q.size()));
        chk("ovf", 64'(ovf_o), 64'(m_ovf));
        chk("drop", 64'(drop_o), 64'(m_drops));
        if (ph == 1) begin
            chk("msg", 64'(mo), 64'(out.m));
            chk("data", dout, out.d);
        end
        if (vld) begin
            pulses.push_back(cyc);
            del_q.push_back(mo.msg_info);
            dmsg  = mo;
            ddata = dout;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        cyc++;
        @(negedge clk);
        compare();
    endtask

    function automatic SB_msg_t mk(input SB_opcode_t op,
                                   input SB_msg_num_t n,
                                   input logic [15:0] info);
        SB_msg_t m;
        m.opcode   = op;
        m.msg_num  = n;
        m.msg_info = info;
        return m;
    endfunction

    function automatic SB_msg_t rand_msg();
        SB_msg_num_t nums[4];
        nums[0] = SBINIT_done_req;
        nums[1] = MBINIT_PARAM_config_req;
        nums[2] = MBINIT_CAL_done_req;
        nums[3] = MBINIT_REPAIRCLK_init_resp;
        return mk($urandom_range(0, 1) ? Message_without_Data
                                       : Message_with_64b_Data,
                  nums[$urandom_range(0, 3)], 16'($urandom));
    endfunction

    task automatic push_msg(input SB_msg_t m, input logic [63:0] d);
        mi = m;
        di = d;
        pv = 1'b1;
        tick();
        pv = 1'b0;
    endtask

    task automatic pop_one();
        int k = 0;
        while (!avail && k < 20) begin
            tick();
            k++;
        end
        chk("pop_wait", 64'(avail), 64'd1);
        rq = 1'b1;
        tick();
        rq = 1'b0;
        tick();
        tick();
    endtask

    task automatic do_flush();
        fl = 1'b1;
        tick();
        fl = 1'b0;
    endtask

    initial begin
        rst = 1'b1; fl = 1'b0; pv = 1'b0; rq = 1'b0;
        mi  = reset_SB_msg(); di = '0;
        @(negedge clk);
        tick();
        rst = 1'b0;
        chk("rst_msg", 64'(mo), 64'(reset_SB_msg()));
        chk("rst_data", dout, 64'd0);
        chk("rst_valid", 64'(vld), 64'd0);

        push_msg(mk(Message_with_64b_Data, MBINIT_PARAM_config_req, 16'h1),
                 64'h1234_5678_9ABC_DEF0);
        chk("t1_level1", 64'(level), 64'd1);
        tick();
        rq = 1'b1;
        tick();
        rq = 1'b0;
        chk("t1_valid", 64'(vld), 64'd1);
        chk("t1_level0", 64'(level), 64'd0);
        chk("t1_data", dout, 64'h1234_5678_9ABC_DEF0);
        chk("t1_num", 64'(mo.msg_num), 64'(MBINIT_PARAM_config_req));
        tick();
        chk("t1_vld_once", 64'(vld), 64'd0);
        chk("t1_gap_av1", 64'(avail), 64'd0);
        tick();
        chk("t1_gap_av2", 64'(avail), 64'd0);

        push_msg(mk(Message_without_Data, MBINIT_CAL_done_req, 16'h2),
                 64'hFFFF_FFFF_FFFF_FFFF);
        pop_one();
        chk("mask_data", ddata, 64'd0);

        del_q.delete();
        for (int i = 0; i < 4; i++)
            push_msg(mk(Message_with_64b_Data, SBINIT_done_req,
                        16'(10 + i)), 64'($urandom));
        chk("wrap_full", 64'(level), 64'd4);
        pop_one();
        pop_one();
        for (int i = 4; i < 6; i++)
            push_msg(mk(Message_with_64b_Data, SBINIT_done_req,
                        16'(10 + i)), 64'($urandom));
        for (int i = 0; i < 4; i++) pop_one();
        chk("wrap_empty", 64'(level), 64'd0);
        chk("wrap_nodrop", 64'(drop_o), 64'd0);
        chk("wrap_cnt", 64'(del_q.size()), 64'd6);
        for (int i = 0; i < 6 && i < del_q.size(); i++)
            chk("wrap_order", 64'(del_q[i]), 64'(10 + i));

        del_q.delete();
        for (int i = 0; i < 7; i++)
            push_msg(mk(Message_with_64b_Data, MBINIT_PARAM_config_resp,
                        16'(20 + i)), 64'($urandom));
        chk("ovf_flag", 64'(ovf_o), 64'd1);
        chk("ovf_cnt", 64'(drop_o), 64'd3);
        for (int i = 0; i < 4; i++) pop_one();
        for (int i = 0; i < 4 && i < del_q.size(); i++)
            chk("ovf_order", 64'(del_q[i]), 64'(20 + i));

        do_flush();
        for (int i = 0; i < 4; i++)
            push_msg(rand_msg(), 64'($urandom));
        mi = rand_msg(); di = 64'($urandom);
        pv = 1'b1; rq = 1'b1;
        tick();
        pv = 1'b0; rq = 1'b0;
        chk("pp_nodrop", 64'(drop_o), 64'd0);
        chk("pp_level", 64'(level), 64'd4);
        for (int i = 0; i < 4; i++) pop_one();

        do_flush();
        push_msg(rand_msg(), 64'($urandom));
        push_msg(rand_msg(), 64'($urandom));
        pulses.delete();
        rq = 1'b1;
        repeat (9) tick();
        rq = 1'b0;
        chk("stale_cnt", 64'(pulses.size()), 64'd2);
        if (pulses.size() == 2)
            chk("stale_gap", 64'(pulses[1] - pulses[0]), 64'd3);

        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 5; i++)
                push_msg(rand_msg(), 64'($urandom));
            rq = 1'b1;
            tick();
            rq = 1'b0;
            chk("mid_deliver", 64'(vld), 64'd1);
            chk("mid_level", 64'(level), 64'd3);
            if (r == 0) fl = 1'b1; else rst = 1'b1;
            tick();
            fl = 1'b0; rst = 1'b0;
            chk("mid_valid0", 64'(vld), 64'd0);
            chk("mid_level0", 64'(level), 64'd0);
            chk("mid_ovf0", 64'(ovf_o), 64'd0);
            chk("mid_drop0", 64'(drop_o), 64'd0);
            repeat (3) begin
                tick();
                chk("mid_avail0", 64'(avail), 64'd0);
            end
        end

        for (int i = 0; i < 3000; i++) begin
            pv = ($urandom_range(0, 99) < 45);
            rq = ($urandom_range(0, 99) < 35);
            fl = ($urandom_range(0, 199) == 0);
            mi = rand_msg();
            di = {$urandom, $urandom};
            tick();
        end
        pv = 1'b0; rq = 1'b0; fl = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
